// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: parametrised pipeline stage register with a 2-entry skid buffer.
//
// Carries NUM_FIELDS packed fields of DATA_W bits between two CPU stages using a
// valid/ready handshake. in_ready is decoded from the state register alone, so the
// upstream stage never sees a combinational path from out_ready. A synchronous flush
// kills everything held (bubble insertion); a saturating counter records cycles in
// which downstream was ready but this stage had nothing to offer.
//
// Ports:
//   clk         clock, rising edge
//   reset       asynchronous active-low reset
//   flush       synchronous kill of all held entries, drops in_data that cycle
//   in_valid    upstream holds a valid bundle
//   in_ready    stage can accept (registered)
//   in_data     upstream bundle, field k = in_data[k*DATA_W +: DATA_W]
//   out_valid   out_data is a valid bundle
//   out_ready   downstream accepts this cycle
//   out_data    bundle to downstream, all-zero when empty
//   occupancy   entries held: 0, 1 or 2
//   bubble_cnt  saturating count of cycles with out_ready=1 and out_valid=0

module pipe_stage_skid #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned NUM_FIELDS   = 4,
  parameter int unsigned BUBBLE_CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_FIELDS*DATA_W-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_FIELDS*DATA_W-1:0] out_data,
  output logic [1:0]                   occupancy,
  output logic [BUBBLE_CNT_W-1:0]      bubble_cnt
);

  localparam int unsigned BundleW = NUM_FIELDS * DATA_W;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e                  state_q, state_d;
  logic [BundleW-1:0]      main_q, main_d;
  logic [BundleW-1:0]      skid_q, skid_d;
  logic [BUBBLE_CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  logic accept;
  logic drain;

  // Outputs depend only on registers.
  assign in_ready  = (state_q != StFull);
  assign out_valid = (state_q != StEmpty);
  assign out_data  = main_q;

  assign accept = in_valid & in_ready & ~flush;
  assign drain  = out_valid & out_ready;

  always_comb begin
    unique case (state_q)
      StOne:   occupancy = 2'd1;
      StFull:  occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // All-zero bundle decodes as a NOP downstream.
      state_d = StEmpty;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d = StOne;
            main_d  = in_data;
          end
        end
        StOne: begin
          if (accept && drain) begin
            main_d = in_data;
          end else if (accept) begin
            state_d = StFull;
            skid_d  = in_data;
          end else if (drain) begin
            state_d = StEmpty;
            main_d  = '0;
          end
        end
        StFull: begin
          // Skid always drains after main to keep FIFO order.
          if (drain) begin
            state_d = StOne;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = StEmpty;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  // Counts in flush cycles too; sticks at all-ones until reset.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (out_ready && !out_valid && !(&bubble_cnt_q)) begin
      bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
  end

  assign bubble_cnt = bubble_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StEmpty;
      main_q       <= '0;
      skid_q       <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

endmodule
